// File: rtl/alu_pkg.sv
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Opcode encodings, FSM state encoding and helpers shared by the
//             multi-cycle MIPS ALU and its bench.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // ALUControle operation codes
  localparam logic [3:0] c_OP_AND   = 4'd0;
  localparam logic [3:0] c_OP_OR    = 4'd1;
  localparam logic [3:0] c_OP_ADD   = 4'd2;
  localparam logic [3:0] c_OP_SUB   = 4'd6;
  localparam logic [3:0] c_OP_SLT   = 4'd7;
  localparam logic [3:0] c_OP_MULT  = 4'd8;
  localparam logic [3:0] c_OP_MULTU = 4'd9;
  localparam logic [3:0] c_OP_DIV   = 4'd10;
  localparam logic [3:0] c_OP_DIVU  = 4'd11;
  localparam logic [3:0] c_OP_NOR   = 4'd12;
  localparam logic [3:0] c_OP_MFHI  = 4'd13;
  localparam logic [3:0] c_OP_MFLO  = 4'd14;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULDIV = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Codes 8..11 are the iterative multiply/divide operations
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_multiciclo_if.sv
// ============================================================================
//  Module   : alu_multiciclo_if
//  Purpose  : Start/done handshake and operand/result bus between the control
//             unit (master) and the multi-cycle ALU (slave).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_multiciclo_if #(
  parameter int WIDTH = 32
);
  logic             Inicio;
  logic [3:0]       ALUControle;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] ResultadoALU;
  logic             Zero;
  logic             Pronto;
  logic             Ocupado;
  logic             Overflow;

  modport master (
    output Inicio, ALUControle, A, B,
    input  ResultadoALU, Zero, Pronto, Ocupado, Overflow
  );

  modport slave (
    input  Inicio, ALUControle, A, B,
    output ResultadoALU, Zero, Pronto, Ocupado, Overflow
  );
endinterface

`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
// ============================================================================
//  Module   : alu_muldiv_seq
//  Purpose  : Iterative 1-bit/cycle multiply (shift-add) and divide (restoring)
//             on operand magnitudes, with sign correction on the outputs.
//             The first iteration is folded into the load cycle so that WIDTH
//             iterations finish WIDTH edges after i_start.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             i_start,   // load operands and run iteration 0
  input  wire logic             i_run,     // run one more iteration
  input  wire logic             i_signed,
  input  wire logic             i_div,
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  output logic                  o_last,    // this cycle performs the final iteration
  output logic [WIDTH-1:0]      o_hi,
  output logic [WIDTH-1:0]      o_lo
);

  localparam int c_CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_ma, r_mb, r_acc, r_shf;
  logic [c_CW-1:0]  r_cnt;
  logic             r_div, r_neg_q, r_neg_r, r_bz;

  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_ma, w_mb, w_acc, w_shf;
  logic [WIDTH-1:0]   w_acc_nx, w_shf_nx;
  logic               w_div;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH+1:0]   w_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q, w_r;

  // One iteration step, fed either by fresh operands (load) or the working registers
  always_comb begin
    w_a_mag = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    w_b_mag = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    if (i_start) begin
      w_div = i_div;
      w_ma  = w_a_mag;
      w_mb  = w_b_mag;
      w_acc = '0;
      w_shf = i_div ? w_a_mag : w_b_mag;
    end else begin
      w_div = r_div;
      w_ma  = r_ma;
      w_mb  = r_mb;
      w_acc = r_acc;
      w_shf = r_shf;
    end
    w_sum   = {1'b0, w_acc} + (w_shf[0] ? {1'b0, w_ma} : {(WIDTH+1){1'b0}});
    w_trial = {1'b0, w_acc, w_shf[WIDTH-1]} - {2'b00, w_mb};
    if (!w_div) begin
      w_acc_nx = w_sum[WIDTH:1];
      w_shf_nx = {w_sum[0], w_shf[WIDTH-1:1]};
    end else if (!w_trial[WIDTH+1]) begin
      w_acc_nx = w_trial[WIDTH-1:0];
      w_shf_nx = {w_shf[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_nx = {w_acc[WIDTH-2:0], w_shf[WIDTH-1]};
      w_shf_nx = {w_shf[WIDTH-2:0], 1'b0};
    end
  end

  // Working registers, operand latches and iteration counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ma    <= '0;
      r_mb    <= '0;
      r_acc   <= '0;
      r_shf   <= '0;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bz    <= 1'b0;
    end else begin
      if (i_start || i_run) begin
        r_acc <= w_acc_nx;
        r_shf <= w_shf_nx;
        r_cnt <= i_start ? c_CW'(1) : r_cnt + c_CW'(1);
      end
      if (i_start) begin
        r_ma    <= w_a_mag;
        r_mb    <= w_b_mag;
        r_div   <= i_div;
        r_neg_q <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        r_neg_r <= i_signed && i_a[WIDTH-1];
        r_bz    <= (i_b == '0);
      end
    end
  end

  assign o_last = (r_cnt == c_CW'(WIDTH - 1));

  // Sign correction; divide by zero forces an all-ones quotient
  always_comb begin
    w_prod = {r_acc, r_shf};
    if (r_neg_q) w_prod = -w_prod;
    w_q = r_shf;
    if (r_bz) w_q = '1;
    else if (r_neg_q) w_q = -r_shf;
    w_r = r_neg_r ? -r_acc : r_acc;
    o_hi = r_div ? w_r : w_prod[2*WIDTH-1:WIDTH];
    o_lo = r_div ? w_q : w_prod[WIDTH-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/alu_multiciclo.sv
// ============================================================================
//  Module   : alu_multiciclo
//  Purpose  : Multi-cycle MIPS ALU: single-cycle AND/OR/ADD/SUB/SLT/NOR/MFHI/
//             MFLO, iterative MULT/MULTU/DIV/DIVU into HI/LO, Inicio/Pronto
//             handshake with Ocupado stall.
//  Options  : ALU_OVERFLOW_EN - registered signed ADD/SUB overflow flag;
//             when undefined the Overflow output is tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic        clock,
  input  wire logic        reset,
  alu_multiciclo_if.slave  bus
);

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_result, r_hi, r_lo;
  logic             r_zero, r_pronto;

  logic [WIDTH-1:0] w_sum, w_diff, w_alu, w_res_nx, w_seq_hi, w_seq_lo;
  logic             w_start, w_run, w_load, w_hilo_we, w_pronto_nx, w_seq_last;
  logic             w_signed, w_div;

  assign w_signed = (bus.ALUControle == c_OP_MULT) || (bus.ALUControle == c_OP_DIV);
  assign w_div    = (bus.ALUControle == c_OP_DIV)  || (bus.ALUControle == c_OP_DIVU);

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clock    (clock),
    .reset    (reset),
    .i_start  (w_start),
    .i_run    (w_run),
    .i_signed (w_signed),
    .i_div    (w_div),
    .i_a      (bus.A),
    .i_b      (bus.B),
    .o_last   (w_seq_last),
    .o_hi     (w_seq_hi),
    .o_lo     (w_seq_lo)
  );

  // Single-cycle operation results
  always_comb begin
    w_sum  = bus.A + bus.B;
    w_diff = bus.A - bus.B;
    case (bus.ALUControle)
      c_OP_AND:  w_alu = bus.A & bus.B;
      c_OP_OR:   w_alu = bus.A | bus.B;
      c_OP_ADD:  w_alu = w_sum;
      c_OP_SUB:  w_alu = w_diff;
      c_OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      c_OP_NOR:  w_alu = ~(bus.A | bus.B);
      c_OP_MFHI: w_alu = r_hi;
      c_OP_MFLO: w_alu = r_lo;
      default:   w_alu = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // FSM next state and datapath controls; Inicio is ignored outside IDLE
  always_comb begin
    w_state_nx  = r_state;
    w_start     = 1'b0;
    w_run       = 1'b0;
    w_load      = 1'b0;
    w_hilo_we   = 1'b0;
    w_pronto_nx = 1'b0;
    w_res_nx    = r_result;
    case (r_state)
      ST_IDLE: begin
        if (bus.Inicio) begin
          if (is_muldiv(bus.ALUControle)) begin
            w_start    = 1'b1;
            w_state_nx = ST_MULDIV;
          end else begin
            w_load      = 1'b1;
            w_res_nx    = w_alu;
            w_pronto_nx = 1'b1;
          end
        end
      end
      ST_MULDIV: begin
        w_run = 1'b1;
        if (w_seq_last) w_state_nx = ST_DONE;
      end
      ST_DONE: begin
        w_hilo_we   = 1'b1;
        w_load      = 1'b1;
        w_res_nx    = w_seq_lo;
        w_pronto_nx = 1'b1;
        w_state_nx  = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Result, Zero, Pronto and HI/LO registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_pronto <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_pronto <= w_pronto_nx;
      if (w_load) begin
        r_result <= w_res_nx;
        r_zero   <= (w_res_nx == '0);
      end
      if (w_hilo_we) begin
        r_hi <= w_seq_hi;
        r_lo <= w_seq_lo;
      end
    end
  end

  assign bus.ResultadoALU = r_result;
  assign bus.Zero         = r_zero;
  assign bus.Pronto       = r_pronto;
  assign bus.Ocupado      = (r_state != ST_IDLE);

`ifdef ALU_OVERFLOW_EN
  logic r_ovf, w_ovf;

  // Signed overflow: operands (A and B for ADD, A and -B for SUB) agree in sign, result does not
  always_comb begin
    w_ovf = 1'b0;
    if (bus.ALUControle == c_OP_ADD)
      w_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
    else if (bus.ALUControle == c_OP_SUB)
      w_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
  end

  // Overflow is loaded with every result; mul/div results clear it
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_ovf <= 1'b0;
    else if (w_load) r_ovf <= (r_state == ST_IDLE) ? w_ovf : 1'b0;
  end

  assign bus.Overflow = r_ovf;
`else
  assign bus.Overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_multiciclo.sv
// ============================================================================
//  Module   : tb_alu_multiciclo
//  Purpose  : Directed self-checking bench for alu_multiciclo (WIDTH=32).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_multiciclo;
  import alu_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  alu_multiciclo_if #(.WIDTH(32)) bus ();

  alu_multiciclo #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Present an operation for one rising edge; returns #1 after that edge with Inicio still high
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.Inicio      = 1'b1;
    bus.ALUControle = op;
    bus.A           = a;
    bus.B           = b;
    @(posedge clock);
    #1;
  endtask

  // Start a mul/div and count edges (issue edge = 1) until Pronto, bounded
  task automatic run_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int n);
    issue(op, a, b);
    bus.Inicio = 1'b0;
    n = 1;
    while (!bus.Pronto && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    issue(c_OP_MFHI, 32'h0, 32'h0);
    hi = bus.ResultadoALU;
    issue(c_OP_MFLO, 32'h0, 32'h0);
    lo = bus.ResultadoALU;
    bus.Inicio = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_vec_t;

  md_vec_t md_vecs[8];

  initial begin
    int          n;
    logic [31:0] hi, lo;
    logic        saw;

    n_checks = 0;
    n_pass   = 0;
    bus.Inicio      = 1'b0;
    bus.ALUControle = 4'd0;
    bus.A           = 32'h0;
    bus.B           = 32'h0;
    reset           = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_result",  {32'h0, bus.ResultadoALU}, 64'h0);
    check("rst_zero",    {63'h0, bus.Zero},     64'h1);
    check("rst_pronto",  {63'h0, bus.Pronto},   64'h0);
    check("rst_ocupado", {63'h0, bus.Ocupado},  64'h0);
    check("rst_ovf",     {63'h0, bus.Overflow}, 64'h0);
    @(negedge clock);
    reset = 1'b0;

    // ADD with signed overflow, result visible after one edge
    issue(c_OP_ADD, 32'h7FFFFFFF, 32'h00000001);
    bus.Inicio = 1'b0;
    check("add_res",    {32'h0, bus.ResultadoALU}, 64'h80000000);
    check("add_zero",   {63'h0, bus.Zero},   64'h0);
    check("add_pronto", {63'h0, bus.Pronto}, 64'h1);
`ifdef ALU_OVERFLOW_EN
    check("add_ovf",    {63'h0, bus.Overflow}, 64'h1);
`else
    check("add_ovf",    {63'h0, bus.Overflow}, 64'h0);
`endif
    @(posedge clock);
    #1;
    check("idle_pronto", {63'h0, bus.Pronto}, 64'h0);
    check("idle_hold",   {32'h0, bus.ResultadoALU}, 64'h80000000);

    // Back-to-back single-cycle ops, Inicio held high
    issue(c_OP_SUB, 32'd5, 32'd5);
    check("sub_res",  {32'h0, bus.ResultadoALU}, 64'h0);
    check("sub_zero", {63'h0, bus.Zero}, 64'h1);
    check("sub_ovf",  {63'h0, bus.Overflow}, 64'h0);
    issue(c_OP_SLT, 32'hFFFFFFFF, 32'h00000001);
    check("slt_res",    {32'h0, bus.ResultadoALU}, 64'h1);
    check("slt_pronto", {63'h0, bus.Pronto}, 64'h1);
    issue(c_OP_SLT, 32'h00000001, 32'hFFFFFFFF);
    check("slt_res2", {32'h0, bus.ResultadoALU}, 64'h0);
    issue(c_OP_NOR, 32'h0, 32'h0);
    check("nor_res", {32'h0, bus.ResultadoALU}, 64'hFFFFFFFF);
    issue(c_OP_AND, 32'hFF00FF00, 32'h0F0F0F0F);
    check("and_res", {32'h0, bus.ResultadoALU}, 64'h0F000F00);
    issue(c_OP_OR, 32'h12340000, 32'h00005678);
    check("or_res", {32'h0, bus.ResultadoALU}, 64'h12345678);
    issue(4'd3, 32'h12345678, 32'h1);
    check("code3_res",  {32'h0, bus.ResultadoALU}, 64'h0);
    check("code3_zero", {63'h0, bus.Zero}, 64'h1);
    bus.Inicio = 1'b0;

    // Multiply / divide vectors
    md_vecs[0] = '{c_OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    md_vecs[1] = '{c_OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    md_vecs[2] = '{c_OP_MULTU, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000};
    md_vecs[3] = '{c_OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    md_vecs[4] = '{c_OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    md_vecs[5] = '{c_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    md_vecs[6] = '{c_OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    md_vecs[7] = '{c_OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    for (int i = 0; i < 8; i++) begin
      run_muldiv(md_vecs[i].op, md_vecs[i].a, md_vecs[i].b, n);
      check($sformatf("md%0d_latency", i), 64'(n), 64'd33);
      check($sformatf("md%0d_res", i),  {32'h0, bus.ResultadoALU}, {32'h0, md_vecs[i].lo});
      check($sformatf("md%0d_zero", i), {63'h0, bus.Zero}, {63'h0, (md_vecs[i].lo == 32'h0)});
      check($sformatf("md%0d_busy", i), {63'h0, bus.Ocupado}, 64'h0);
      read_hilo(hi, lo);
      check($sformatf("md%0d_hi", i), {32'h0, hi}, {32'h0, md_vecs[i].hi});
      check($sformatf("md%0d_lo", i), {32'h0, lo}, {32'h0, md_vecs[i].lo});
    end

    // ADD issued mid-MULT must be ignored
    issue(c_OP_MULT, 32'h00000005, 32'hFFFFFFFD);
    bus.Inicio = 1'b0;
    check("mid_busy0", {63'h0, bus.Ocupado}, 64'h1);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    issue(c_OP_ADD, 32'h1, 32'h2);
    bus.Inicio = 1'b0;
    n = 6;
    check("mid_pronto", {63'h0, bus.Pronto}, 64'h0);
    check("mid_busy",   {63'h0, bus.Ocupado}, 64'h1);
    check("mid_hold",   {32'h0, bus.ResultadoALU}, 64'hFFFFFFFF);
    while (!bus.Pronto && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("mid_latency", 64'(n), 64'd33);
    check("mid_res", {32'h0, bus.ResultadoALU}, 64'hFFFFFFF1);
    read_hilo(hi, lo);
    check("mid_hi", {32'h0, hi}, 64'hFFFFFFFF);
    check("mid_lo", {32'h0, lo}, 64'hFFFFFFF1);

    // Load HI/LO with nonzero values, then reset in the middle of a DIV
    run_muldiv(c_OP_DIVU, 32'h7, 32'h0, n);
    issue(c_OP_DIV, 32'h00000064, 32'h00000007);
    bus.Inicio = 1'b0;
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    #1;
    check("abort_busy",   {63'h0, bus.Ocupado}, 64'h0);
    check("abort_pronto", {63'h0, bus.Pronto},  64'h0);
    check("abort_res",    {32'h0, bus.ResultadoALU}, 64'h0);
    check("abort_zero",   {63'h0, bus.Zero}, 64'h1);
    @(negedge clock);
    reset = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      saw = saw | bus.Pronto;
    end
    check("abort_no_pronto", {63'h0, saw}, 64'h0);
    read_hilo(hi, lo);
    check("abort_hi", {32'h0, hi}, 64'h0);
    check("abort_lo", {32'h0, lo}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
